// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline control inputs and the hazard unit outputs.
// master drives the ID-stage description and pipeline events; slave is the hazard unit.
interface hazard_ctrl_if;
   logic        id_valid;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rt;
   logic [4:0]  id_rd;
   logic        id_regwrite;
   logic        id_memread;
   logic        branch_taken;
   logic        mem_busy;
   logic [1:0]  c_data1_src;
   logic [1:0]  c_data2_src;
   logic        stall;
   logic        flush;
   logic        freeze;
   logic [15:0] stall_count;

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_regwrite, id_memread,
             branch_taken, mem_busy,
      input  c_data1_src, c_data2_src, stall, flush, freeze, stall_count
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_regwrite, id_memread,
             branch_taken, mem_busy,
      output c_data1_src, c_data2_src, stall, flush, freeze, stall_count
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard unit for a 5-stage MIPS-style pipeline: tracks the EX, MEM and WB
// slots, selects ALU operand forwarding, detects load-use stalls, flushes on a
// taken branch, freezes on a busy data memory and counts lost cycles.
module hazard_ctrl (
   input logic          clk,
   input logic          rst,
   hazard_ctrl_if.slave bus
);

   localparam logic [1:0] SRC_REG = 2'b00;
   localparam logic [1:0] SRC_MEM = 2'b10;
   localparam logic [1:0] SRC_WB  = 2'b01;

   // EX slot (_p0), MEM slot (_p1), WB slot (_p2)
   logic        vld_p0;
   logic [4:0]  rs_p0;
   logic [4:0]  rt_p0;
   logic        uses_rt_p0;
   logic [4:0]  rd_p0;
   logic        regwrite_p0;
   logic        memread_p0;

   logic        vld_p1;
   logic [4:0]  rd_p1;
   logic        regwrite_p1;

   logic        vld_p2;
   logic [4:0]  rd_p2;
   logic        regwrite_p2;

   logic [15:0] stall_cnt;

   logic        prod_p0;
   logic        prod_p1;
   logic        prod_p2;
   logic        load_use;
   logic        stall_c;
   logic        flush_c;
   logic        freeze_c;
   logic        bubble;

   // A slot can forward only if it will really write a non-zero register.
   function automatic logic is_producer(input logic vld, input logic regwrite,
                                        input logic [4:0] rd);
      return vld && regwrite && (rd != 5'd0);
   endfunction

   // EX/MEM beats MEM/WB so the youngest value of a register wins.
   function automatic logic [1:0] fwd_sel(input logic ex_vld, input logic [4:0] src,
                                          input logic mem_prod, input logic [4:0] mem_rd,
                                          input logic wb_prod, input logic [4:0] wb_rd);
      logic [1:0] sel;
      sel = SRC_REG;
      if (ex_vld && mem_prod && (mem_rd == src))
         sel = SRC_MEM;
      else if (wb_prod && (wb_rd == src))
         sel = SRC_WB;
      return sel;
   endfunction

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] val);
      return (val == 16'hFFFF) ? val : val + 16'd1;
   endfunction

   // Combinational hazard decisions from the slots and the current ID inputs.
   always_comb begin
      prod_p0  = is_producer(vld_p0, regwrite_p0, rd_p0);
      prod_p1  = is_producer(vld_p1, regwrite_p1, rd_p1);
      prod_p2  = is_producer(vld_p2, regwrite_p2, rd_p2);
      load_use = bus.id_valid && prod_p0 && memread_p0 &&
                 ((rd_p0 == bus.id_rs) || (bus.id_uses_rt && (rd_p0 == bus.id_rt)));
      flush_c  = bus.branch_taken && vld_p0;
      stall_c  = load_use && !flush_c;
      freeze_c = bus.mem_busy;
      bubble   = stall_c || flush_c;
   end

   // Operand source selects; operand 2 only forwards when rt is actually read.
   always_comb begin
      bus.c_data1_src = fwd_sel(vld_p0, rs_p0, prod_p1, rd_p1, prod_p2, rd_p2);
      bus.c_data2_src = SRC_REG;
      if (uses_rt_p0)
         bus.c_data2_src = fwd_sel(vld_p0, rt_p0, prod_p1, rd_p1, prod_p2, rd_p2);
   end

   assign bus.stall       = stall_c;
   assign bus.flush       = flush_c;
   assign bus.freeze      = freeze_c;
   assign bus.stall_count = stall_cnt;

   // Slot shift register: ID->EX (or bubble), EX->MEM, MEM->WB; held on freeze.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0      <= 1'b0;
         rs_p0       <= 5'd0;
         rt_p0       <= 5'd0;
         uses_rt_p0  <= 1'b0;
         rd_p0       <= 5'd0;
         regwrite_p0 <= 1'b0;
         memread_p0  <= 1'b0;
         vld_p1      <= 1'b0;
         rd_p1       <= 5'd0;
         regwrite_p1 <= 1'b0;
         vld_p2      <= 1'b0;
         rd_p2       <= 5'd0;
         regwrite_p2 <= 1'b0;
      end else if (!freeze_c) begin
         // MEM -> WB
         vld_p2      <= vld_p1;
         rd_p2       <= rd_p1;
         regwrite_p2 <= regwrite_p1;
         // EX -> MEM
         vld_p1      <= vld_p0;
         rd_p1       <= rd_p0;
         regwrite_p1 <= regwrite_p0;
         // ID -> EX; a bubble carries zeroed fields so it can never match
         if (bubble) begin
            vld_p0      <= 1'b0;
            rs_p0       <= 5'd0;
            rt_p0       <= 5'd0;
            uses_rt_p0  <= 1'b0;
            rd_p0       <= 5'd0;
            regwrite_p0 <= 1'b0;
            memread_p0  <= 1'b0;
         end else begin
            vld_p0      <= bus.id_valid;
            rs_p0       <= bus.id_rs;
            rt_p0       <= bus.id_rt;
            uses_rt_p0  <= bus.id_uses_rt;
            rd_p0       <= bus.id_rd;
            regwrite_p0 <= bus.id_regwrite;
            memread_p0  <= bus.id_memread;
         end
      end
   end

   // Lost-cycle counter: any stall, flush or freeze costs one cycle.
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= 16'd0;
      else if (stall_c || flush_c || freeze_c)
         stall_cnt <= sat_inc(stall_cnt);
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, $0, branch flush,
// freeze, reset-mid-stall and counter saturation.
module tb_hazard_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   hazard_ctrl_if hif ();

   hazard_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (hif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish, required finish before 2000000");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic ut, input logic [4:0] rd, input logic rw,
                         input logic mr);
      hif.id_valid    = v;
      hif.id_rs       = rs;
      hif.id_rt       = rt;
      hif.id_uses_rt  = ut;
      hif.id_rd       = rd;
      hif.id_regwrite = rw;
      hif.id_memread  = mr;
      #1;
   endtask

   task automatic nop();
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      nop();
      repeat (3) tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      hif.branch_taken = 1'b0;
      hif.mem_busy = 1'b0;
      nop();
      repeat (2) tick();
      rst = 1'b0;
      #1;

      // Reset state
      check("rst_c1", 32'(hif.c_data1_src), 32'd0);
      check("rst_c2", 32'(hif.c_data2_src), 32'd0);
      check("rst_stall", 32'(hif.stall), 32'd0);
      check("rst_flush", 32'(hif.flush), 32'd0);
      check("rst_freeze", 32'(hif.freeze), 32'd0);
      check("rst_count", 32'(hif.stall_count), 32'd0);

      // add $3,$1,$2 ; sub $4,$3,$5
      set_id(1, 5'd1, 5'd2, 1, 5'd3, 1, 0); tick();
      set_id(1, 5'd3, 5'd5, 1, 5'd4, 1, 0);
      check("exmem_pre_c1", 32'(hif.c_data1_src), 32'd0);
      tick(); nop();
      check("exmem_c1", 32'(hif.c_data1_src), 32'b10);
      check("exmem_c2", 32'(hif.c_data2_src), 32'b00);
      drain();

      // add $3 ; add $3 ; or $6,$3,$3
      set_id(1, 5'd1, 5'd2, 1, 5'd3, 1, 0); tick();
      set_id(1, 5'd4, 5'd5, 1, 5'd3, 1, 0); tick();
      set_id(1, 5'd3, 5'd3, 1, 5'd6, 1, 0); tick(); nop();
      check("double_c1", 32'(hif.c_data1_src), 32'b10);
      check("double_c2", 32'(hif.c_data2_src), 32'b10);
      drain();

      // add $3 ; add $8 ; sub $11,$3,$8 -> rs from WB, rt from MEM
      set_id(1, 5'd1, 5'd2, 1, 5'd3, 1, 0); tick();
      set_id(1, 5'd9, 5'd10, 1, 5'd8, 1, 0); tick();
      set_id(1, 5'd3, 5'd8, 1, 5'd11, 1, 0); tick(); nop();
      check("mixed_c1", 32'(hif.c_data1_src), 32'b01);
      check("mixed_c2", 32'(hif.c_data2_src), 32'b10);
      drain();

      // add $3 ; addi $13,$0 with rt field 3 not read -> operand 2 stays register
      set_id(1, 5'd1, 5'd2, 1, 5'd3, 1, 0); tick();
      set_id(1, 5'd0, 5'd3, 0, 5'd13, 1, 0); tick(); nop();
      check("no_rt_c2", 32'(hif.c_data2_src), 32'b00);
      drain();

      // lw $2,0($1) ; and $4,$2,$5
      set_id(1, 5'd1, 5'd2, 0, 5'd2, 1, 1); tick();
      set_id(1, 5'd2, 5'd5, 1, 5'd4, 1, 0);
      check("lu_stall", 32'(hif.stall), 32'd1);
      tick();
      check("lu_stall_once", 32'(hif.stall), 32'd0);
      check("lu_count", 32'(hif.stall_count), 32'd1);
      check("lu_bubble_c1", 32'(hif.c_data1_src), 32'b00);
      tick(); nop();
      check("lu_c1", 32'(hif.c_data1_src), 32'b01);
      check("lu_c2", 32'(hif.c_data2_src), 32'b00);
      check("lu_count2", 32'(hif.stall_count), 32'd1);
      drain();

      // addi $0,$0,5 ; add $7,$0,$0
      set_id(1, 5'd0, 5'd0, 0, 5'd0, 1, 0); tick();
      set_id(1, 5'd0, 5'd0, 1, 5'd7, 1, 0); tick(); nop();
      check("zero_c1", 32'(hif.c_data1_src), 32'b00);
      check("zero_c2", 32'(hif.c_data2_src), 32'b00);
      drain();

      // beq in EX taken, and $4,$2,$5 in ID
      set_id(1, 5'd1, 5'd2, 1, 5'd0, 0, 0); tick();
      hif.branch_taken = 1'b1;
      set_id(1, 5'd2, 5'd5, 1, 5'd4, 1, 0);
      check("br_flush", 32'(hif.flush), 32'd1);
      check("br_stall", 32'(hif.stall), 32'd0);
      tick();
      check("br_ex_empty", 32'(hif.flush), 32'd0);
      check("br_count", 32'(hif.stall_count), 32'd2);
      hif.branch_taken = 1'b0;
      drain();

      // lw $2 in EX with dependent use in ID and a taken branch: flush wins
      set_id(1, 5'd1, 5'd2, 0, 5'd2, 1, 1); tick();
      hif.branch_taken = 1'b1;
      set_id(1, 5'd2, 5'd5, 1, 5'd4, 1, 0);
      check("prio_flush", 32'(hif.flush), 32'd1);
      check("prio_stall", 32'(hif.stall), 32'd0);
      tick();
      hif.branch_taken = 1'b0;
      nop();
      check("prio_count", 32'(hif.stall_count), 32'd3);
      drain();

      // Freeze for 3 cycles during an EX/MEM forward
      set_id(1, 5'd1, 5'd2, 1, 5'd3, 1, 0); tick();
      set_id(1, 5'd3, 5'd5, 1, 5'd4, 1, 0); tick(); nop();
      check("frz_pre_c1", 32'(hif.c_data1_src), 32'b10);
      hif.mem_busy = 1'b1;
      #1;
      check("frz_freeze", 32'(hif.freeze), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("frz_c1", 32'(hif.c_data1_src), 32'b10);
         check("frz_c2", 32'(hif.c_data2_src), 32'b00);
      end
      check("frz_count", 32'(hif.stall_count), 32'd6);
      hif.mem_busy = 1'b0;
      #1;
      check("frz_release", 32'(hif.freeze), 32'd0);
      drain();

      // Reset asserted during a load-use stall
      set_id(1, 5'd1, 5'd2, 0, 5'd2, 1, 1); tick();
      set_id(1, 5'd2, 5'd5, 1, 5'd4, 1, 0);
      check("rs_stall", 32'(hif.stall), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      nop();
      check("rs_c1", 32'(hif.c_data1_src), 32'd0);
      check("rs_c2", 32'(hif.c_data2_src), 32'd0);
      check("rs_stall0", 32'(hif.stall), 32'd0);
      check("rs_flush", 32'(hif.flush), 32'd0);
      check("rs_freeze", 32'(hif.freeze), 32'd0);
      check("rs_count", 32'(hif.stall_count), 32'd0);
      // Slots must be empty: a taken branch now finds no valid EX
      hif.branch_taken = 1'b1;
      #1;
      check("rs_ex_empty", 32'(hif.flush), 32'd0);
      hif.branch_taken = 1'b0;

      // Saturation
      hif.mem_busy = 1'b1;
      repeat (65534) @(posedge clk);
      #1;
      check("sat_fffe", 32'(hif.stall_count), 32'h0000FFFE);
      tick();
      check("sat_ffff", 32'(hif.stall_count), 32'h0000FFFF);
      tick();
      check("sat_hold", 32'(hif.stall_count), 32'h0000FFFF);
      hif.mem_busy = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
